// File: rtl/ex_wb_lane_pipe.sv
// Multi-lane post-EX pipeline (stage 1 = MEM ... last stage = WB) with load merge, full
// operand forwarding, branch kill and load-use detection. Define PIPE_PERF_CNT_EN for perf counters.
module ex_wb_lane_pipe #(
   parameter int  NUM_LANES  = 2,
   parameter int  NUM_STAGES = 2,
   parameter int  NUM_SRC    = 4,
   localparam int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stall,
   input  logic                    flush,
   input  logic [NUM_LANES-1:0]    ex_valid,
   input  logic [NUM_LANES-1:0]    ex_rf_we,
   input  logic [5*NUM_LANES-1:0]  ex_rf_waddr,
   input  logic [32*NUM_LANES-1:0] ex_result,
   input  logic [NUM_LANES-1:0]    ex_is_load,
   input  logic                    ex_br_valid,
   input  logic [LANE_W-1:0]       ex_br_lane,
   input  logic [32*NUM_LANES-1:0] mem_rdata,
   input  logic [5*NUM_SRC-1:0]    src_raddr,
   input  logic [32*NUM_SRC-1:0]   src_rdata,
   output logic [32*NUM_SRC-1:0]   src_rdata_f,
   output logic [NUM_SRC-1:0]      load_use_hazard,
   output logic [NUM_LANES-1:0]    wb_rf_we,
   output logic [5*NUM_LANES-1:0]  wb_rf_waddr,
   output logic [32*NUM_LANES-1:0] wb_rf_wdata,
   output logic [31:0]             perf_stall_cnt,
   output logic [31:0]             perf_bubble_cnt
);
   localparam int LAST = NUM_STAGES - 1;

   // Stage index 0 is MEM, index LAST is WB.
   logic [NUM_LANES-1:0] st_valid [NUM_STAGES];
   logic [NUM_LANES-1:0] st_we    [NUM_STAGES];
   logic [4:0]           st_waddr [NUM_STAGES][NUM_LANES];
   logic [31:0]          st_data  [NUM_STAGES][NUM_LANES];
   logic [NUM_LANES-1:0] s1_is_load;

   logic [NUM_LANES-1:0] in_valid;
   logic [NUM_LANES-1:0] in_we;

   // NOTE: every always_comb output is given a default first so no path can infer a latch.
   always_comb begin
      in_valid = '0;
      in_we    = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         in_valid[i] = ex_valid[i] & ~flush & ~(ex_br_valid & (i > int'(ex_br_lane)));
         in_we[i]    = in_valid[i] & ex_rf_we[i] & (ex_rf_waddr[5*i +: 5] != 5'd0);
      end
   end

   // NOTE: the stage arrays are cleared on reset; a stale we/waddr would otherwise forward garbage.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_is_load <= '0;
         for (int s = 0; s < NUM_STAGES; s++) begin
            st_valid[s] <= '0;
            st_we[s]    <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
               st_waddr[s][l] <= '0;
               st_data[s][l]  <= '0;
            end
         end
      end else if (!stall) begin
         // NOTE: non-blocking updates let every stage read its predecessor's old value, so loop order is irrelevant.
         for (int l = 0; l < NUM_LANES; l++) begin
            st_valid[0][l] <= in_valid[l];
            st_we[0][l]    <= in_we[l];
            st_waddr[0][l] <= ex_rf_waddr[5*l +: 5];
            st_data[0][l]  <= ex_result[32*l +: 32];
            s1_is_load[l]  <= in_valid[l] & ex_is_load[l];
            st_valid[1][l] <= st_valid[0][l];
            st_we[1][l]    <= st_we[0][l];
            st_waddr[1][l] <= st_waddr[0][l];
            st_data[1][l]  <= s1_is_load[l] ? mem_rdata[32*l +: 32] : st_data[0][l];
         end
         for (int s = 2; s < NUM_STAGES; s++) begin
            st_valid[s] <= st_valid[s-1];
            st_we[s]    <= st_we[s-1];
            for (int l = 0; l < NUM_LANES; l++) begin
               st_waddr[s][l] <= st_waddr[s-1][l];
               st_data[s][l]  <= st_data[s-1][l];
            end
         end
      end
   end

   // Youngest stage first; within a stage the higher (younger) lane wins.
   always_comb begin : fwd_comb
      logic       found;
      logic [4:0] raddr;
      src_rdata_f     = src_rdata;
      load_use_hazard = '0;
      found           = 1'b0;
      raddr           = '0;
      for (int j = 0; j < NUM_SRC; j++) begin
         found = 1'b0;
         raddr = src_raddr[5*j +: 5];
         if (raddr != 5'd0) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
               for (int l = NUM_LANES - 1; l >= 0; l--) begin
                  if (!found && st_valid[s][l] && st_we[s][l] && (st_waddr[s][l] == raddr)) begin
                     found                    = 1'b1;
                     src_rdata_f[32*j +: 32]  = st_data[s][l];
                     load_use_hazard[j]       = (s == 0) && s1_is_load[l];
                  end
               end
            end
         end
      end
   end

   always_comb begin
      wb_rf_we    = '0;
      wb_rf_waddr = '0;
      wb_rf_wdata = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         wb_rf_we[l]              = st_valid[LAST][l] & st_we[LAST][l];
         wb_rf_waddr[5*l +: 5]    = st_waddr[LAST][l];
         wb_rf_wdata[32*l +: 32]  = st_data[LAST][l];
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] bubble_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (stall) begin
         stall_cnt <= stall_cnt + 32'd1;
      end else if (|(ex_valid & ~in_valid)) begin
         bubble_cnt <= bubble_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt  = stall_cnt;
   assign perf_bubble_cnt = bubble_cnt;
`else
   assign perf_stall_cnt  = '0;
   assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_wb_lane_pipe.sv
// Self-checking bench for ex_wb_lane_pipe: directed table, hand-written corner sequences,
// and randomized traffic checked against a slot-level reference model.
module tb_ex_wb_lane_pipe;
   localparam int NL   = 2;
   localparam int NS   = 2;
   localparam int NSRC = 4;
`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              stall;
   logic              flush;
   logic [NL-1:0]     ex_valid;
   logic [NL-1:0]     ex_rf_we;
   logic [5*NL-1:0]   ex_rf_waddr;
   logic [32*NL-1:0]  ex_result;
   logic [NL-1:0]     ex_is_load;
   logic              ex_br_valid;
   logic [0:0]        ex_br_lane;
   logic [32*NL-1:0]  mem_rdata;
   logic [5*NSRC-1:0] src_raddr;
   logic [32*NSRC-1:0] src_rdata;
   logic [32*NSRC-1:0] src_rdata_f;
   logic [NSRC-1:0]   load_use_hazard;
   logic [NL-1:0]     wb_rf_we;
   logic [5*NL-1:0]   wb_rf_waddr;
   logic [32*NL-1:0]  wb_rf_wdata;
   logic [31:0]       perf_stall_cnt;
   logic [31:0]       perf_bubble_cnt;

   ex_wb_lane_pipe #(.NUM_LANES(NL), .NUM_STAGES(NS), .NUM_SRC(NSRC)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
      .ex_result(ex_result), .ex_is_load(ex_is_load), .ex_br_valid(ex_br_valid),
      .ex_br_lane(ex_br_lane), .mem_rdata(mem_rdata), .src_raddr(src_raddr),
      .src_rdata(src_rdata), .src_rdata_f(src_rdata_f), .load_use_hazard(load_use_hazard),
      .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
      .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: one slot per (stage, lane); "we" already folds in validity.
   typedef struct {
      bit          we;
      bit          ld;
      logic [4:0]  a;
      logic [31:0] d;
   } slot_t;

   slot_t       pipe [NS][NL];
   logic [31:0] m_stall;
   logic [31:0] m_bubble;

   task automatic tick();
      bit dropped;
      bit keep;
      dropped = 1'b0;
      if (rst) begin
         for (int s = 0; s < NS; s++)
            for (int l = 0; l < NL; l++)
               pipe[s][l] = '{we: 1'b0, ld: 1'b0, a: 5'd0, d: 32'd0};
         m_stall  = '0;
         m_bubble = '0;
      end else if (stall) begin
         m_stall = m_stall + 32'd1;
      end else begin
         for (int s = NS - 1; s >= 1; s--) begin
            for (int l = 0; l < NL; l++) begin
               pipe[s][l] = pipe[s-1][l];
               if (s == 1 && pipe[s][l].ld) pipe[s][l].d = mem_rdata[32*l +: 32];
               pipe[s][l].ld = 1'b0;
            end
         end
         for (int l = 0; l < NL; l++) begin
            keep = ex_valid[l] && !flush && !(ex_br_valid && (l > int'(ex_br_lane)));
            if (ex_valid[l] && !keep) dropped = 1'b1;
            pipe[0][l] = '{we: keep && ex_rf_we[l] && (ex_rf_waddr[5*l +: 5] != 5'd0),
                           ld: keep && ex_is_load[l],
                           a:  ex_rf_waddr[5*l +: 5],
                           d:  ex_result[32*l +: 32]};
         end
         if (dropped) m_bubble = m_bubble + 32'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic m_fwd(input logic [4:0] ra, input logic [31:0] rf,
                        output logic [31:0] d, output bit haz);
      bit found;
      d     = rf;
      haz   = 1'b0;
      found = 1'b0;
      if (ra != 5'd0) begin
         for (int s = 0; s < NS; s++)
            for (int l = NL - 1; l >= 0; l--)
               if (!found && pipe[s][l].we && pipe[s][l].a == ra) begin
                  found = 1'b1;
                  d     = pipe[s][l].d;
                  haz   = (s == 0) && pipe[s][l].ld;
               end
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] d;
      bit          haz;
      for (int j = 0; j < NSRC; j++) begin
         m_fwd(src_raddr[5*j +: 5], src_rdata[32*j +: 32], d, haz);
         check($sformatf("%s_haz%0d", tag, j), 32'(load_use_hazard[j]), 32'(haz));
         if (!haz) check($sformatf("%s_fwd%0d", tag, j), src_rdata_f[32*j +: 32], d);
      end
   endtask

   task automatic check_model_wb(input string tag);
      for (int l = 0; l < NL; l++) begin
         check($sformatf("%s_we%0d", tag, l), 32'(wb_rf_we[l]), 32'(pipe[NS-1][l].we));
         if (pipe[NS-1][l].we) begin
            check($sformatf("%s_wa%0d", tag, l), 32'(wb_rf_waddr[5*l +: 5]), 32'(pipe[NS-1][l].a));
            check($sformatf("%s_wd%0d", tag, l), wb_rf_wdata[32*l +: 32], pipe[NS-1][l].d);
         end
      end
      check({tag, "_stallcnt"}, perf_stall_cnt, PERF_EN ? m_stall : 32'd0);
      check({tag, "_bubblecnt"}, perf_bubble_cnt, PERF_EN ? m_bubble : 32'd0);
   endtask

   task automatic clr_ex();
      ex_valid    = '0;
      ex_rf_we    = '0;
      ex_rf_waddr = '0;
      ex_result   = '0;
      ex_is_load  = '0;
      ex_br_valid = 1'b0;
      ex_br_lane  = '0;
      flush       = 1'b0;
   endtask

   task automatic set_lane(input int l, input logic we, input logic [4:0] a,
                           input logic [31:0] d, input logic ld);
      ex_valid[l]            = 1'b1;
      ex_rf_we[l]            = we;
      ex_rf_waddr[5*l +: 5]  = a;
      ex_result[32*l +: 32]  = d;
      ex_is_load[l]          = ld;
   endtask

   task automatic exp_wb(input string nm, input logic [1:0] we, input logic [4:0] a0, a1,
                         input logic [31:0] d0, d1);
      check({nm, "_we"}, 32'(wb_rf_we), 32'(we));
      if (we[0]) begin
         check({nm, "_a0"}, 32'(wb_rf_waddr[4:0]), 32'(a0));
         check({nm, "_d0"}, wb_rf_wdata[31:0], d0);
      end
      if (we[1]) begin
         check({nm, "_a1"}, 32'(wb_rf_waddr[9:5]), 32'(a1));
         check({nm, "_d1"}, wb_rf_wdata[63:32], d1);
      end
   endtask

   task automatic chk_src(input string nm, input int j, input logic [31:0] exp);
      check(nm, src_rdata_f[32*j +: 32], exp);
   endtask

   typedef struct {
      logic [1:0]  v, we;
      logic [4:0]  a0, a1;
      logic [31:0] d0, d1;
      logic        br, bl, fl;
      logic [1:0]  e_we;
      logic [4:0]  e_a0, e_a1;
      logic [31:0] e_d0, e_d1;
   } vec_t;

   function automatic vec_t mk(logic [1:0] v, we, logic [4:0] a0, a1, logic [31:0] d0, d1,
                               logic br, bl, fl, logic [1:0] ewe, logic [4:0] ea0, ea1,
                               logic [31:0] ed0, ed1);
      vec_t r;
      r = '{v: v, we: we, a0: a0, a1: a1, d0: d0, d1: d1, br: br, bl: bl, fl: fl,
            e_we: ewe, e_a0: ea0, e_a1: ea1, e_d0: ed0, e_d1: ed1};
      return r;
   endfunction

   vec_t tbl [7];

   initial begin
      // Each row: EX bundle driven for one edge, then the WB bundle expected right after that edge.
      tbl[0] = mk(2'b11, 2'b11, 5,  6,  32'h11,  32'h22,   0, 0, 0, 2'b00, 0, 0,  0,      0);
      tbl[1] = mk(2'b11, 2'b11, 7,  8,  32'h77,  32'h88,   1, 0, 0, 2'b11, 5, 6,  32'h11, 32'h22);
      tbl[2] = mk(2'b01, 2'b01, 0,  0,  32'h55,  32'h0,    0, 0, 0, 2'b01, 7, 0,  32'h77, 0);
      tbl[3] = mk(2'b11, 2'b10, 9,  10, 32'h100, 32'h101,  0, 0, 1, 2'b00, 0, 0,  0,      0);
      tbl[4] = mk(2'b10, 2'b10, 0,  12, 32'h0,   32'h1212, 1, 1, 0, 2'b00, 0, 0,  0,      0);
      tbl[5] = mk(2'b00, 2'b00, 0,  0,  32'h0,   32'h0,    0, 0, 0, 2'b10, 0, 12, 0,      32'h1212);
      tbl[6] = mk(2'b00, 2'b00, 0,  0,  32'h0,   32'h0,    0, 0, 0, 2'b00, 0, 0,  0,      0);

      rst       = 1'b1;
      stall     = 1'b0;
      clr_ex();
      mem_rdata = '0;
      src_raddr = '0;
      src_rdata = {32'h1234_0003, 32'h1234_0002, 32'h1234_0001, 32'h1234_0000};
      tick();
      tick();

      check("reset_we", 32'(wb_rf_we), 32'd0);
      check("reset_waddr", 32'(wb_rf_waddr), 32'd0);
      check("reset_wdata_lo", wb_rf_wdata[31:0], 32'd0);
      check("reset_wdata_hi", wb_rf_wdata[63:32], 32'd0);
      check("reset_stallcnt", perf_stall_cnt, 32'd0);
      check("reset_bubblecnt", perf_bubble_cnt, 32'd0);
      rst       = 1'b0;
      src_raddr = {5'd0, 5'd0, 5'd0, 5'd5};
      #1;
      chk_src("reset_fwd_empty", 0, 32'h1234_0000);

      // Pass-through, branch kill, r0 writes, flush, kill with branch on the last lane.
      for (int i = 0; i < 7; i++) begin
         ex_valid    = tbl[i].v;
         ex_rf_we    = tbl[i].we;
         ex_rf_waddr = {tbl[i].a1, tbl[i].a0};
         ex_result   = {tbl[i].d1, tbl[i].d0};
         ex_is_load  = '0;
         ex_br_valid = tbl[i].br;
         ex_br_lane  = tbl[i].bl;
         flush       = tbl[i].fl;
         tick();
         exp_wb($sformatf("tbl%0d", i), tbl[i].e_we, tbl[i].e_a0, tbl[i].e_a1, tbl[i].e_d0, tbl[i].e_d1);
      end
      clr_ex();
      check("tbl_bubblecnt", perf_bubble_cnt, PERF_EN ? 32'd2 : 32'd0);
      check("tbl_stallcnt", perf_stall_cnt, 32'd0);

      // Forwarding priority: stage 1 beats stage 2, and the higher lane beats the lower one.
      set_lane(1, 1'b1, 5'd3, 32'hAA, 1'b0);
      tick();
      clr_ex();
      set_lane(0, 1'b1, 5'd3, 32'hBB, 1'b0);
      tick();
      clr_ex();
      src_raddr = {5'd0, 5'd4, 5'd0, 5'd3};
      #1;
      chk_src("fwd_s1_over_s2", 0, 32'hBB);
      chk_src("fwd_raddr0", 1, 32'h1234_0001);
      chk_src("fwd_miss", 2, 32'h1234_0002);
      set_lane(0, 1'b1, 5'd3, 32'hC0, 1'b0);
      set_lane(1, 1'b1, 5'd3, 32'hC1, 1'b0);
      tick();
      clr_ex();
      #1;
      chk_src("fwd_lane1_wins", 0, 32'hC1);
      tick();
      chk_src("fwd_last_stage", 0, 32'hC1);
      exp_wb("fwd_wb", 2'b11, 5'd3, 5'd3, 32'hC0, 32'hC1);

      // Load-use hazard while the load sits in stage 1, then merged data one edge later.
      set_lane(1, 1'b1, 5'd9, 32'h4000, 1'b1);
      tick();
      clr_ex();
      src_raddr = {5'd0, 5'd9, 5'd0, 5'd0};
      #1;
      check("lu_hazard", 32'(load_use_hazard), 32'h4);
      mem_rdata = {32'hDEAD_BEEF, 32'h0};
      tick();
      mem_rdata = '0;
      #1;
      check("lu_cleared", 32'(load_use_hazard), 32'h0);
      chk_src("lu_merged_fwd", 2, 32'hDEAD_BEEF);
      exp_wb("lu_wb", 2'b10, 5'd0, 5'd9, 32'h0, 32'hDEAD_BEEF);

      // Stall for three edges: everything holds and the stalled EX bundle (and flush) is ignored.
      set_lane(0, 1'b1, 5'd13, 32'h1313, 1'b0);
      tick();
      clr_ex();
      set_lane(1, 1'b1, 5'd15, 32'h1515, 1'b0);
      tick();
      exp_wb("pre_stall", 2'b01, 5'd13, 5'd0, 32'h1313, 32'h0);
      clr_ex();
      set_lane(0, 1'b1, 5'd14, 32'h1414, 1'b0);
      stall     = 1'b1;
      flush     = 1'b1;
      src_raddr = {5'd0, 5'd0, 5'd14, 5'd15};
      for (int k = 0; k < 3; k++) begin
         tick();
         exp_wb($sformatf("stall_hold%0d", k), 2'b01, 5'd13, 5'd0, 32'h1313, 32'h0);
         chk_src($sformatf("stall_fwd_held%0d", k), 0, 32'h1515);
         chk_src($sformatf("stall_ex_not_taken%0d", k), 1, 32'h1234_0001);
      end
      check("stall_cnt3", perf_stall_cnt, PERF_EN ? 32'd3 : 32'd0);
      check("stall_no_bubble", perf_bubble_cnt, PERF_EN ? 32'd2 : 32'd0);
      stall = 1'b0;
      clr_ex();
      tick();
      exp_wb("stall_release", 2'b10, 5'd0, 5'd15, 32'h0, 32'h1515);
      tick();
      exp_wb("stall_dropped", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

      // Reset asserted during a stall wins over the hold.
      set_lane(0, 1'b1, 5'd20, 32'h2020, 1'b0);
      tick();
      clr_ex();
      tick();
      exp_wb("prerst_wb", 2'b01, 5'd20, 5'd0, 32'h2020, 32'h0);
      stall = 1'b1;
      tick();
      exp_wb("prerst_hold", 2'b01, 5'd20, 5'd0, 32'h2020, 32'h0);
      rst = 1'b1;
      tick();
      check("rst_stall_we", 32'(wb_rf_we), 32'd0);
      check("rst_stall_waddr", 32'(wb_rf_waddr), 32'd0);
      check("rst_stall_wdata", wb_rf_wdata[31:0] | wb_rf_wdata[63:32], 32'd0);
      check("rst_stall_cnt", perf_stall_cnt, 32'd0);
      check("rst_bubble_cnt", perf_bubble_cnt, 32'd0);
      rst   = 1'b0;
      stall = 1'b0;

      // Randomized traffic against the reference model; small register space to force hits.
      for (int c = 0; c < 600; c++) begin
         ex_valid    = NL'($urandom);
         ex_rf_we    = NL'($urandom);
         ex_is_load  = NL'($urandom);
         ex_br_valid = ($urandom_range(0, 4) == 0);
         ex_br_lane  = 1'($urandom);
         flush       = ($urandom_range(0, 9) == 0);
         stall       = ($urandom_range(0, 4) == 0);
         for (int l = 0; l < NL; l++) begin
            ex_rf_waddr[5*l +: 5] = 5'($urandom_range(0, 7));
            ex_result[32*l +: 32] = $urandom;
            mem_rdata[32*l +: 32] = $urandom;
         end
         for (int j = 0; j < NSRC; j++) begin
            src_raddr[5*j +: 5]  = 5'($urandom_range(0, 7));
            src_rdata[32*j +: 32] = $urandom;
         end
         #1;
         check_model($sformatf("rnd%0d", c));
         tick();
         check_model_wb($sformatf("rnd%0d", c));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
